// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// State encodings are shared so the arbiter and its watchdog use one source.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_DM = 2'd2
   } arb_state_e;

   localparam int unsigned DEF_MAX_DM_STREAK = 4;
   localparam int unsigned DEF_TIMEOUT       = 15;

   // Bits needed to hold values 0..max_val inclusive, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Access watchdog: counts busy cycles without mem_ready and flags expiry
// on the last permitted cycle so the arbiter can abort on the next edge.
module mem_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned   CW = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

   logic [CW-1:0] wd_cnt_q;
   logic [CW-1:0] wd_cnt_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (clr_i) begin
         wd_cnt_d = '0;
      end else if (en_i && (wd_cnt_q != TC)) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end

   assign expire_o = en_i && (wd_cnt_q == TC);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// with a DM streak limit for IF fairness and a watchdog abort on hung accesses.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ARB_IDLE     | no access in flight; grants when neither ack is pulsing
//   ARB_BUSY_IF  | fetch access on the memory bus, waiting for mem_ready
//   ARB_BUSY_DM  | load/store access on the memory bus, waiting for mem_ready
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned MAX_DM_STREAK = DEF_MAX_DM_STREAK,
   parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  if_stall,
   output logic                  dm_stall,
   output logic                  bus_err
);

   localparam int unsigned   SW       = cnt_width(MAX_DM_STREAK);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

   arb_state_e            state_q;
   logic [SW-1:0]         dm_streak_q;
   logic                  mem_req_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] dm_rdata_q;
   logic                  if_ack_q;
   logic                  dm_ack_q;
   logic                  bus_err_q;

   logic                  grant_open;
   logic                  streak_full;
   logic                  grant_if;
   logic                  grant_dm;
   logic                  busy;
   logic                  wd_expire;

   // The ack cycle is a dead IDLE cycle: the acked requester still holds req.
   assign grant_open  = (state_q == ARB_IDLE) && !if_ack_q && !dm_ack_q;
   assign streak_full = (dm_streak_q == STREAK_MAX);
   assign grant_if    = grant_open && if_req && (!dm_req || streak_full);
   assign grant_dm    = grant_open && dm_req && !grant_if;
   assign busy        = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_DM);

   mem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (grant_if || grant_dm),
      .en_i     (busy && !mem_ready),
      .expire_o (wd_expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         dm_streak_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         if_ack_q  <= 1'b0;
         dm_ack_q  <= 1'b0;
         bus_err_q <= 1'b0;
         unique case (state_q)
            ARB_IDLE: begin
               if (grant_if) begin
                  state_q     <= ARB_BUSY_IF;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= if_addr;
                  dm_streak_q <= '0;
               end else if (grant_dm) begin
                  state_q     <= ARB_BUSY_DM;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= dm_we;
                  mem_addr_q  <= dm_addr;
                  mem_wdata_q <= dm_wdata;
                  if (!if_req) begin
                     dm_streak_q <= '0;
                  end else if (!streak_full) begin
                     dm_streak_q <= dm_streak_q + 1'b1;
                  end
               end
            end
            ARB_BUSY_IF, ARB_BUSY_DM: begin
               if (mem_ready || wd_expire) begin
                  state_q   <= ARB_IDLE;
                  mem_req_q <= 1'b0;
                  bus_err_q <= !mem_ready;
                  if (state_q == ARB_BUSY_IF) begin
                     if_ack_q <= 1'b1;
                     if (mem_ready) begin
                        if_rdata_q <= mem_rdata;
                     end
                  end else begin
                     dm_ack_q <= 1'b1;
                     if (mem_ready && !mem_we_q) begin
                        dm_rdata_q <= mem_rdata;
                     end
                  end
               end
            end
            default: begin
               state_q   <= ARB_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign dm_rdata  = dm_rdata_q;
   assign dm_ack    = dm_ack_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign bus_err   = bus_err_q;
   assign if_stall  = if_req & ~if_ack_q;
   assign dm_stall  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-programmable memory responder,
// a grant-order monitor and hand-computed expectations per scenario.
module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          if_req    = 1'b0;
   logic [AW-1:0] if_addr   = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          dm_req    = 1'b0;
   logic          dm_we     = 1'b0;
   logic [AW-1:0] dm_addr   = '0;
   logic [DW-1:0] dm_wdata  = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic          if_stall;
   logic          dm_stall;
   logic          bus_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .MAX_DM_STREAK (4),
      .TIMEOUT       (15)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ack    (dm_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .if_stall  (if_stall),
      .dm_stall  (dm_stall),
      .bus_err   (bus_err)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Memory responder: ready after rdy_lat cycles of mem_req (0 = never).
   int          rdy_lat   = 0;
   logic        rdy_force = 1'b0;
   int          hi_cnt    = 0;
   logic [31:0] rd_val    = '0;
   always @(negedge clk) begin
      if (mem_req) hi_cnt = hi_cnt + 1;
      else         hi_cnt = 0;
      mem_ready = rdy_force || (mem_req && (rdy_lat != 0) && (hi_cnt == rdy_lat));
      mem_rdata = rd_val;
   end

   string order   = "";
   logic  prev_mr = 1'b0;
   always @(negedge clk) begin
      if (mem_req && !prev_mr) begin
         if (mem_addr == if_addr) order = {order, "I"};
         else                     order = {order, "D"};
      end
      prev_mr = mem_req;
   end

   // Protocol: a request must stay up until its ack.
   logic if_pend = 1'b0;
   logic dm_pend = 1'b0;
   always @(posedge clk) begin
      if (rst_n) begin
         a_if_hold: assert (!(if_pend && !if_req)) else $error("if_req dropped before if_ack");
         a_dm_hold: assert (!(dm_pend && !dm_req)) else $error("dm_req dropped before dm_ack");
      end
      if_pend <= rst_n && if_req && !if_ack;
      dm_pend <= rst_n && dm_req && !dm_ack;
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      if_req    = 1'b0;
      dm_req    = 1'b0;
      rdy_force = 1'b0;
      rdy_lat   = 0;
      nxt();
      nxt();
      rst_n = 1'b1;
   endtask

   int   c_ack, c_ifack, rise_c, err_c, stall_bad, both_ack;
   logic seen, we_seen, berr_if;

   initial begin
      // reset state
      do_reset();
      check_val("rst_mem_req",   mem_req,   32'd0);
      check_val("rst_mem_we",    mem_we,    32'd0);
      check_val("rst_acks_err",  {if_ack, dm_ack, bus_err}, 32'd0);
      check_val("rst_mem_addr",  mem_addr,  32'd0);
      check_val("rst_mem_wdata", mem_wdata, 32'd0);
      check_val("rst_rdata",     if_rdata | dm_rdata, 32'd0);

      // IF-only fetch, ready on third busy cycle
      order = ""; rd_val = 32'hDEADBEEF; rdy_lat = 3;
      if_addr = 32'h10; if_req = 1'b1;
      c_ack = -1; we_seen = 1'b0; seen = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         nxt();
         if (c == 2) check_val("if_stall_busy", if_stall, 32'd1);
         if (if_ack && c_ack < 0) begin
            c_ack = c;
            check_val("if_stall_ack", if_stall, 32'd0);
         end
         if (mem_we) we_seen = 1'b1;
         if (dm_ack) seen = 1'b1;
         if (c_ack >= 0 && c == c_ack + 1) if_req = 1'b0;
      end
      check_val("if_ack_cycle", c_ack, 32'd4);
      check_val("if_rdata", if_rdata, 32'hDEADBEEF);
      check_val("if_mem_we_low", we_seen, 32'd0);
      check_val("if_no_dm_ack", seen, 32'd0);
      check_val("if_single_grant", order == "I", 32'd1);

      // store with ready in the first busy cycle
      do_reset();
      order = ""; rd_val = 32'hCAFEF00D; rdy_lat = 1;
      dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h1234; dm_req = 1'b1;
      c_ack = -1; seen = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         nxt();
         if (c == 1) begin
            check_val("st_mem_req",   mem_req,   32'd1);
            check_val("st_mem_we",    mem_we,    32'd1);
            check_val("st_mem_addr",  mem_addr,  32'h20);
            check_val("st_mem_wdata", mem_wdata, 32'h1234);
            check_val("st_dm_stall",  dm_stall,  32'd1);
         end
         if (dm_ack && c_ack < 0) c_ack = c;
         if (if_ack) seen = 1'b1;
         if (c_ack >= 0 && c == c_ack + 1) dm_req = 1'b0;
      end
      check_val("st_ack_cycle", c_ack, 32'd2);
      check_val("st_dm_rdata_kept", dm_rdata, 32'd0);
      check_val("st_no_if_ack", seen, 32'd0);

      // both held, latency 1: four DM grants then one IF
      do_reset();
      order = ""; rd_val = 32'h11112222; rdy_lat = 1;
      if_addr = 32'h100; dm_addr = 32'h200; dm_we = 1'b0;
      if_req = 1'b1; dm_req = 1'b1;
      stall_bad = 0; both_ack = 0;
      for (int c = 1; c <= 31; c++) begin
         nxt();
         if (if_stall !== !if_ack) stall_bad++;
         if (if_ack && dm_ack) both_ack++;
      end
      check_val("rr_order", order.substr(0, 9) == "DDDDIDDDDI", 32'd1);
      check_val("rr_if_stall", stall_bad, 32'd0);
      check_val("rr_ack_exclusive", both_ack, 32'd0);
      check_val("rr_if_rdata", if_rdata, 32'h11112222);
      check_val("rr_dm_rdata", dm_rdata, 32'h11112222);

      // DM load never ready: watchdog abort, then pending IF
      do_reset();
      order = ""; rd_val = 32'h77777777; rdy_lat = 0;
      dm_we = 1'b0; dm_addr = 32'h300; if_addr = 32'h400;
      dm_req = 1'b1; if_req = 1'b1;
      rise_c = -1; c_ack = -1; c_ifack = -1; err_c = -1; berr_if = 1'b0;
      for (int c = 1; c <= 26; c++) begin
         nxt();
         if (mem_req && rise_c < 0) rise_c = c;
         if (dm_ack && c_ack < 0) begin
            c_ack = c;
            if (bus_err) err_c = c;
            check_val("to_mem_req_drop", mem_req, 32'd0);
         end
         if (if_ack && c_ifack < 0) begin
            c_ifack = c;
            berr_if = bus_err;
         end
         if (c_ack >= 0 && c == c_ack + 1) begin
            dm_req = 1'b0; rdy_lat = 2; rd_val = 32'h000055AA;
         end
         if (c_ifack >= 0 && c == c_ifack + 1) if_req = 1'b0;
      end
      check_val("to_mem_req_rise", rise_c, 32'd1);
      check_val("to_dm_ack_cycle", c_ack, 32'd16);
      check_val("to_bus_err_cycle", err_c, 32'd16);
      check_val("to_dm_rdata_kept", dm_rdata, 32'd0);
      check_val("to_if_ack_cycle", c_ifack, 32'd20);
      check_val("to_if_no_bus_err", berr_if, 32'd0);
      check_val("to_if_rdata", if_rdata, 32'h000055AA);
      check_val("to_order", order == "DI", 32'd1);

      // reset mid-fetch abandons the access; late mem_ready ignored
      order = ""; rdy_lat = 0; if_addr = 32'h500; if_req = 1'b1;
      for (int c = 1; c <= 3; c++) nxt();
      check_val("rs_busy", mem_req, 32'd1);
      rst_n = 1'b0; if_req = 1'b0;
      nxt();
      check_val("rs_mem_req", mem_req, 32'd0);
      check_val("rs_mem_addr", mem_addr, 32'd0);
      check_val("rs_if_rdata", if_rdata, 32'd0);
      check_val("rs_if_ack", if_ack, 32'd0);
      rst_n = 1'b1; rdy_force = 1'b1; seen = 1'b0; we_seen = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         nxt();
         if (if_ack || dm_ack || bus_err) seen = 1'b1;
         if (mem_req) we_seen = 1'b1;
      end
      rdy_force = 1'b0;
      check_val("rs_no_late_ack", seen, 32'd0);
      check_val("rs_no_mem_req", we_seen, 32'd0);

      // load ack coincides with if_req rising: no regrant, IF next, streak clear
      do_reset();
      order = ""; rd_val = 32'h0BADF00D; rdy_lat = 2;
      dm_we = 1'b0; dm_addr = 32'h600; if_addr = 32'h700; dm_req = 1'b1;
      for (int c = 1; c <= 3; c++) nxt();
      check_val("ld_dm_ack", dm_ack, 32'd1);
      check_val("ld_dm_rdata", dm_rdata, 32'h0BADF00D);
      if_req = 1'b1;
      nxt();
      check_val("ld_no_regrant", mem_req, 32'd0);
      dm_req = 1'b0;
      nxt();
      check_val("ld_if_grant", mem_req, 32'd1);
      check_val("ld_if_addr", mem_addr, 32'h700);
      check_val("ld_if_we", mem_we, 32'd0);
      dm_req = 1'b1;
      for (int c = 6; c <= 30; c++) nxt();
      check_val("ld_order", order.substr(0, 6) == "DIDDDDI", 32'd1);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_time_limit: bench did not finish, expected completion");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store driven by mem_write_enable from the control unit).
- Sequences each access as a request/ready transaction with variable memory latency.
- Returns read data and a one-cycle ack to the winning port.
- Stalls the losing port; aborts hung accesses through a watchdog.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 32, word address width.
- MAX_DM_STREAK, 4, consecutive data-port grants allowed while IF waits.
- TIMEOUT, 15, max cycles waiting for mem_ready before abort; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetched instruction; valid when if_ack=1, held until next if_ack.
- if_ack  out  1  one-cycle completion pulse.
- dm_req  in  1  data request; held with addr/we/wdata until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_rdata  out  DATA_WIDTH  load data; valid when dm_ack=1, held until next dm_ack.
- dm_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory access active.
- mem_we  out  1  write strobe; only meaningful with mem_req.
- mem_addr  out  ADDR_WIDTH  registered address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_rdata  in  DATA_WIDTH  memory read data; sampled when mem_ready=1.
- mem_ready  in  1  memory completes current access this cycle.
- if_stall  out  1  if_req & ~if_ack; combinational.
- dm_stall  out  1  dm_req & ~dm_ack; combinational.
- bus_err  out  1  one-cycle pulse coincident with an ack caused by timeout.

Behaviour:
- Reset (rst_n=0 at edge):
  - State IDLE.
  - mem_req, mem_we, if_ack, dm_ack and bus_err all 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata all 0.
  - dm_streak and wd_cnt both 0.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE:
  - Requests are evaluated every cycle.
  - Grant rule: dm_req wins, unless if_req=1 and dm_streak==MAX_DM_STREAK, in which case IF wins.
  - On grant, next edge:
    - Register address (and we/wdata for DM; mem_we=0 for IF).
    - mem_req=1, wd_cnt=0.
    - Move to BUSY_x.
  - No request: stay in IDLE, mem_req=0.
- BUSY_x:
  - mem_req and mem_* stay stable.
  - If mem_ready=1:
    - Next edge: capture mem_rdata into x_rdata (unchanged on store) and pulse x_ack=1.
    - mem_req=0; return to IDLE.
  - Otherwise wd_cnt increments. When wd_cnt==TIMEOUT-1 with no ready:
    - Next edge: pulse x_ack=1 and bus_err=1; x_rdata is left unchanged.
    - mem_req=0; return to IDLE.
- Latency: request seen in IDLE at cycle 0 -> mem_req at cycle 1 -> mem_ready at cycle k (k>=1) -> ack at cycle k+1.
  - Minimum 2 cycles.
  - One dead IDLE cycle between back-to-back transactions. The ack cycle is IDLE; a requester's req is still high during its own ack cycle and must not be re-granted. IDLE masks any req whose ack is asserted that same cycle.
- dm_streak update:
  - +1 on each DM grant while if_req=1, saturating at MAX_DM_STREAK.
  - Cleared on an IF grant, or on a DM grant when if_req=0.
- mem_ready in IDLE is ignored.
- A request dropped before its ack is a protocol violation; behaviour is not defined, and the bench flags it with an assertion.
- Reset asserted mid-transaction abandons it: no ack, mem_req=0 next cycle, any later mem_ready ignored.
- if_ack and dm_ack are never high in the same cycle.
- At most one mem transaction is outstanding.

Decomposition:
- lapido_defs.v gains:
  - state encodings ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM (2 bits);
  - default MAX_DM_STREAK and TIMEOUT constants.
- Sub-module mem_watchdog: a counter with clear/enable inputs and an expire output, parameterised by TIMEOUT. It is instantiated once.
- Grant selection stays inline.

Test Plan:
- IF-only fetch, addr=0x10, mem_ready 3 cycles after mem_req, mem_rdata=0xDEADBEEF -> if_ack at cycle 4, if_rdata=0xDEADBEEF, mem_we=0 throughout, dm_ack never set.
- Store, dm_addr=0x20, dm_wdata=0x1234 (dm_we=1), mem_ready same cycle mem_req rises -> mem_we=1, mem_wdata=0x1234, dm_ack 2 cycles after request, dm_rdata unchanged.
- if_req and dm_req both held continuously, ready latency 1 (MAX_DM_STREAK=4) -> grant order DM,DM,DM,DM,IF repeating; if_stall high until each if_ack.
- Memory never asserts ready on a DM load (TIMEOUT=15) -> dm_ack and bus_err pulse together 15 cycles after mem_req rises; mem_req drops; a pending IF request is granted next.
- rst_n pulled low during BUSY_IF, then mem_ready asserted after release -> no if_ack, mem_req=0 after reset edge, outputs at reset values, late mem_ready ignored.
- Load whose dm_ack coincides with if_req rising -> dm_req not re-granted in ack cycle; IF granted next, dm_streak cleared.
